seg_anim_seq: RTL and testbench

SEG_ANIM_SEQ -- requirements
Module: seg_anim_seq

---
 rtl/seg_anim_seq_pkg.sv | 42 ++++
 rtl/seg_pattern_rom.sv | 56 +++++
 rtl/seg_anim_seq.sv | 90 +++++++++
 tb/tb_seg_anim_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg_anim_seq_pkg.sv
// Shared types and constants for the seven-segment ring animation sequencer.
package seg_anim_seq_pkg;

    typedef enum logic [1:0] {
        CCW_FILL  = 2'd0,
        CW_FILL   = 2'd1,
        CCW_CHASE = 2'd2,
        CW_CHASE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;
    localparam logic [6:0] SEG_ALL = 7'b111_1111;

    localparam logic [6:0] S_A = 7'(1) << SEG_A;
    localparam logic [6:0] S_B = 7'(1) << SEG_B;
    localparam logic [6:0] S_C = 7'(1) << SEG_C;
    localparam logic [6:0] S_D = 7'(1) << SEG_D;
    localparam logic [6:0] S_E = 7'(1) << SEG_E;
    localparam logic [6:0] S_F = 7'(1) << SEG_F;
    // Outer ring a..f; the middle bar g is never part of the animation.
    localparam logic [6:0] SEG_RING = S_A | S_B | S_C | S_D | S_E | S_F;

    // Fill modes run 8 steps, chase modes 6.
    function automatic logic [2:0] last_step(input mode_e m);
        return (m == CCW_CHASE || m == CW_CHASE) ? 3'd5 : 3'd7;
    endfunction

endpackage

// File: rtl/seg_pattern_rom.sv
// Combinational (mode, step) -> 7-bit segment pattern lookup.
module seg_pattern_rom
    import seg_anim_seq_pkg::*;
(
    input  mode_e      mode,
    input  logic [2:0] step,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (mode)
            CCW_FILL: case (step)
                3'd0:    pattern = S_A;
                3'd1:    pattern = S_A | S_F;
                3'd2:    pattern = S_A | S_F | S_E;
                3'd3:    pattern = S_A | S_F | S_E | S_D;
                3'd4:    pattern = S_A | S_F | S_E | S_D | S_C;
                3'd5:    pattern = SEG_RING;
                3'd6:    pattern = SEG_OFF;
                default: pattern = SEG_RING;
            endcase
            CW_FILL: case (step)
                3'd0:    pattern = S_A;
                3'd1:    pattern = S_A | S_B;
                3'd2:    pattern = S_A | S_B | S_C;
                3'd3:    pattern = S_A | S_B | S_C | S_D;
                3'd4:    pattern = S_A | S_B | S_C | S_D | S_E;
                3'd5:    pattern = SEG_RING;
                3'd6:    pattern = SEG_OFF;
                default: pattern = SEG_RING;
            endcase
            CCW_CHASE: case (step)
                3'd0:    pattern = S_A;
                3'd1:    pattern = S_F;
                3'd2:    pattern = S_E;
                3'd3:    pattern = S_D;
                3'd4:    pattern = S_C;
                3'd5:    pattern = S_B;
                default: pattern = SEG_OFF;
            endcase
            CW_CHASE: case (step)
                3'd0:    pattern = S_A;
                3'd1:    pattern = S_B;
                3'd2:    pattern = S_C;
                3'd3:    pattern = S_D;
                3'd4:    pattern = S_E;
                3'd5:    pattern = S_F;
                default: pattern = SEG_OFF;
            endcase
            default: pattern = SEG_OFF;
        endcase
        pattern[SEG_G] = 1'b0;
    end

endmodule

// File: rtl/seg_anim_seq.sv
// Seven-segment ring animation: prescaler, IDLE/RUN/PAUSE FSM, step counter, registered outputs.
module seg_anim_seq
    import seg_anim_seq_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_pause,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_period,
    output logic [6:0]       o_segment,
    output logic [2:0]       o_step,
    output logic             o_wrap
);

    localparam logic [6:0] POL = ACTIVE_LOW ? SEG_ALL : SEG_OFF;

    state_e           state, state_nx;
    logic [DIV_W-1:0] presc, presc_nx;
    logic [2:0]       step, step_nx;
    mode_e            mode_q, mode_nx;
    logic [6:0]       seg_q, pat;
    logic             wrap_q;
    logic             active, tick, wrap_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_enable) state_nx = RUN;
            RUN:     if (!i_enable) state_nx = IDLE;
                     else if (i_pause) state_nx = PAUSE;
            PAUSE:   if (!i_enable) state_nx = IDLE;
                     else if (!i_pause) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Counting stops in the very cycle pause is raised, not one cycle later.
    always_comb begin
        active    = (state == RUN) && i_enable && !i_pause;
        tick      = active && (presc >= i_period);
        wrap_tick = tick && (step == last_step(mode_q));
        presc_nx  = tick ? '0 : (active ? presc + 1'b1 : presc);
        step_nx   = wrap_tick ? 3'd0 : (tick ? step + 3'd1 : step);
        mode_nx   = (state == IDLE || wrap_tick) ? mode_e'(i_mode) : mode_q;
    end

    // Pattern is looked up from next-cycle mode/step so the output register
    // shows step 0 on the first RUN cycle and follows each tick by one clock.
    seg_pattern_rom u_rom (
        .mode    (mode_nx),
        .step    (step_nx),
        .pattern (pat)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc  <= '0;
            step   <= 3'd0;
            mode_q <= CCW_FILL;
            seg_q  <= POL;
            wrap_q <= 1'b0;
        end else if (state_nx == IDLE) begin
            presc  <= '0;
            step   <= 3'd0;
            mode_q <= mode_nx;
            seg_q  <= POL;
            wrap_q <= 1'b0;
        end else begin
            presc  <= presc_nx;
            step   <= step_nx;
            mode_q <= mode_nx;
            seg_q  <= pat ^ POL;
            wrap_q <= wrap_tick;
        end
    end

    assign o_segment = seg_q;
    assign o_step    = step;
    assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_seg_anim_seq.sv
// Directed bench for seg_anim_seq: vector table plus multi-cycle corner sequences.
module tb_seg_anim_seq;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic             pause = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [DIV_W-1:0] period = '0;
    logic [6:0]       seg, seg_al;
    logic [2:0]       stp, stp_al;
    logic             wrap, wrap_al;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_anim_seq #(.DIV_W(DIV_W), .ACTIVE_LOW(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pause(pause),
        .i_mode(mode), .i_period(period),
        .o_segment(seg), .o_step(stp), .o_wrap(wrap)
    );

    seg_anim_seq #(.DIV_W(DIV_W), .ACTIVE_LOW(1'b1)) dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pause(pause),
        .i_mode(mode), .i_period(period),
        .o_segment(seg_al), .o_step(stp_al), .o_wrap(wrap_al)
    );

    typedef struct {
        logic             en;
        logic             pause;
        logic [1:0]       mode;
        logic [DIV_W-1:0] period;
        logic [6:0]       seg;
        logic [2:0]       stp;
        logic             wrap;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [6:0] es, input logic [2:0] est, input logic ew);
        logic [6:0] inv;
        inv = ~es;
        chk({name, ".seg"}, {25'd0, seg}, {25'd0, es});
        chk({name, ".step"}, {29'd0, stp}, {29'd0, est});
        chk({name, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
        chk({name, ".seg_al"}, {25'd0, seg_al}, {25'd0, inv});
        chk({name, ".step_al"}, {29'd0, stp_al}, {29'd0, est});
        chk({name, ".wrap_al"}, {31'd0, wrap_al}, {31'd0, ew});
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_idle();
        en = 1'b0;
        pause = 1'b0;
        clk_n(1);
    endtask

    initial begin
        // mode 0, period 0: one fill step per cycle, wrap back to step 0
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0000001, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0100001, 3'd1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0110001, 3'd2, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0111001, 3'd3, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0111101, 3'd4, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0111111, 3'd5, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0000000, 3'd6, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0111111, 3'd7, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0000001, 3'd0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 16'd0, 7'b0100001, 3'd1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 16'd0, 7'b0000000, 3'd0, 1'b0};

        // Async reset state, checked before any clock edge
        #2 rst_n = 1'b0;
        #2 chk_out("reset_async", 7'b0000000, 3'd0, 1'b0);
        clk_n(1);
        chk_out("reset_held", 7'b0000000, 3'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            en = tbl[i].en;
            pause = tbl[i].pause;
            mode = tbl[i].mode;
            period = tbl[i].period;
            clk_n(1);
            chk_out($sformatf("vec%0d", i), tbl[i].seg, tbl[i].stp, tbl[i].wrap);
        end

        // CW chase, period 2: each segment held 3 cycles, wrap every 18
        go_idle();
        mode = 2'd3; period = 16'd2; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            int s;
            logic [6:0] e;
            clk_n(1);
            s = (k / 3) % 6;
            e = 7'(1) << s;
            chk_out($sformatf("cw_chase%0d", k), e, 3'(s), k == 18);
        end

        // Mode change mid-fill only takes effect after the wrap
        go_idle();
        mode = 2'd0; period = 16'd0; en = 1'b1;
        clk_n(4);
        chk_out("mchg_s3", 7'b0111001, 3'd3, 1'b0);
        mode = 2'd2;
        clk_n(1); chk_out("mchg_s4", 7'b0111101, 3'd4, 1'b0);
        clk_n(1); chk_out("mchg_s5", 7'b0111111, 3'd5, 1'b0);
        clk_n(1); chk_out("mchg_s6", 7'b0000000, 3'd6, 1'b0);
        clk_n(1); chk_out("mchg_s7", 7'b0111111, 3'd7, 1'b0);
        clk_n(1); chk_out("mchg_wrap", 7'b0000001, 3'd0, 1'b1);
        clk_n(1); chk_out("mchg_c1", 7'b0100000, 3'd1, 1'b0);
        clk_n(1); chk_out("mchg_c2", 7'b0010000, 3'd2, 1'b0);

        // Pause at step 4 with prescaler part-way; resume keeps the count
        go_idle();
        mode = 2'd0; period = 16'd3; en = 1'b1;
        clk_n(17);
        chk_out("pause_reach", 7'b0111101, 3'd4, 1'b0);
        clk_n(2);
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            clk_n(1);
            chk_out($sformatf("pause%0d", k), 7'b0111101, 3'd4, 1'b0);
        end
        pause = 1'b0;
        clk_n(2);
        chk_out("resume_hold", 7'b0111101, 3'd4, 1'b0);
        clk_n(1);
        chk_out("resume_tick", 7'b0111111, 3'd5, 1'b0);
        pause = 1'b1; en = 1'b0;
        clk_n(1);
        chk_out("en_over_pause", 7'b0000000, 3'd0, 1'b0);

        // Enable dropped at step 5
        go_idle();
        mode = 2'd0; period = 16'd0; en = 1'b1;
        clk_n(6);
        chk_out("drop_s5", 7'b0111111, 3'd5, 1'b0);
        en = 1'b0;
        clk_n(1); chk_out("drop_off", 7'b0000000, 3'd0, 1'b0);
        clk_n(2); chk_out("drop_stay", 7'b0000000, 3'd0, 1'b0);

        // Reset mid-count, then restart from IDLE
        mode = 2'd1; period = 16'd5; en = 1'b1;
        clk_n(8);
        chk_out("rst_pre", 7'b0000011, 3'd1, 1'b0);
        rst_n = 1'b0;
        #1 chk_out("rst_mid", 7'b0000000, 3'd0, 1'b0);
        clk_n(1);
        rst_n = 1'b1;
        clk_n(1);
        chk_out("rst_restart", 7'b0000001, 3'd0, 1'b0);

        // Period lowered below the running prescaler
        go_idle();
        mode = 2'd3; period = 16'd100; en = 1'b1;
        clk_n(51);
        chk_out("per_p50", 7'b0000001, 3'd0, 1'b0);
        period = 16'd5;
        clk_n(1); chk_out("per_tick", 7'b0000010, 3'd1, 1'b0);
        clk_n(5); chk_out("per_hold", 7'b0000010, 3'd1, 1'b0);
        clk_n(1); chk_out("per_next", 7'b0000100, 3'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
